spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile.sv | 211 +++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave in front of a small register file.
// One command word (bit MSB = write, low bits = address) then one data word.
// All SPI pins are resynchronised into clk; the host port reads and writes the
// same register file directly.
//
// Handshake: spi_wr_valid is a one-clk pulse with no ready; spi_wr_addr and
// spi_wr_data are stable in that cycle and the register write lands on the same edge.
module spi_slave_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  host_wr_en,
  input  logic [ADDR_BITS-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  spi_wr_valid,
  output logic [ADDR_BITS-1:0]  spi_wr_addr,
  output logic [DATA_WIDTH-1:0] spi_wr_data,
  output logic                  busy
);

  localparam int NREGS = 1 << ADDR_BITS;
  localparam int CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic [1:0] sync_ready_q;
  logic cs_armed_q, cs_armed_d;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_BITS-1:0]  cmd_addr_q, cmd_addr_d;
  logic                  data_rose_q, data_rose_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  spi_we;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, last_bit;
  logic [DATA_WIDTH-1:0] rx_shift;

  // Two-flop synchronisers plus a previous-value flop for edge detection.
  // sync_ready_q marks when the synchronisers hold real samples after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta_q  <= 1'b0;
      sclk_sync_q  <= 1'b0;
      sclk_prev_q  <= 1'b0;
      cs_meta_q    <= 1'b1;
      cs_sync_q    <= 1'b1;
      cs_prev_q    <= 1'b1;
      mosi_meta_q  <= 1'b0;
      mosi_sync_q  <= 1'b0;
      sync_ready_q <= 2'b00;
      cs_armed_q   <= 1'b0;
    end else begin
      sclk_meta_q  <= sclk;
      sclk_sync_q  <= sclk_meta_q;
      sclk_prev_q  <= sclk_sync_q;
      cs_meta_q    <= cs;
      cs_sync_q    <= cs_meta_q;
      cs_prev_q    <= cs_sync_q;
      mosi_meta_q  <= mosi;
      mosi_sync_q  <= mosi_meta_q;
      sync_ready_q <= {sync_ready_q[0], 1'b1};
      cs_armed_q   <= cs_armed_d;
    end
  end

  // Edge detection; a cs already low when reset releases never arms a transaction.
  always_comb begin
    sclk_rise  = sclk_sync_q & ~sclk_prev_q;
    sclk_fall  = ~sclk_sync_q & sclk_prev_q;
    cs_rise    = cs_sync_q & ~cs_prev_q;
    cs_fall    = cs_armed_q & cs_prev_q & ~cs_sync_q;
    cs_armed_d = cs_armed_q | (sync_ready_q[1] & cs_sync_q);
    rx_shift   = {rx_q[DATA_WIDTH-2:0], mosi_sync_q};
    last_bit   = (cnt_q == CW'(DATA_WIDTH - 1));
  end

  // Next-state and datapath logic for the command / data sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    data_rose_d = data_rose_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    spi_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          rx_d    = '0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          rx_d = rx_shift;
          if (last_bit) begin
            cmd_wr_d    = rx_shift[DATA_WIDTH-1];
            cmd_addr_d  = rx_shift[ADDR_BITS-1:0];
            // Read port sees the pre-edge contents, so a same-cycle host write is not visible.
            tx_d        = regs_q[rx_shift[ADDR_BITS-1:0]];
            cnt_d       = '0;
            data_rose_d = 1'b0;
            state_d     = DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          data_rose_d = 1'b0;
        end else if (sclk_rise) begin
          rx_d        = rx_shift;
          data_rose_d = 1'b1;
          if (last_bit) begin
            state_d = WAIT;
            cnt_d   = '0;
            if (cmd_wr_q) begin
              spi_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = cmd_addr_q;
              wr_data_d  = rx_shift;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall && data_rose_q) begin
          // The fall trailing the last command bit must not consume the first data bit.
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      WAIT: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state register for the transaction FSM and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      data_rose_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      data_rose_q <= data_rose_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file; the SPI write is ordered last so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (host_wr_en) regs_q[host_addr] <= host_wr_data;
      if (spi_we) regs_q[cmd_addr_q] <= rx_shift;
    end
  end

  assign host_rd_data = regs_q[host_addr];
  assign miso         = (state_q == DATA) & tx_q[DATA_WIDTH-1];
  assign busy         = (state_q != IDLE);
  assign spi_wr_valid = wr_valid_q;
  assign spi_wr_addr  = wr_addr_q;
  assign spi_wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed scenarios plus randomized transactions
// checked against a register-array model and an expected-write queue.
module tb_spi_slave_regfile;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi, host_wr_en;
  logic [2:0] host_addr;
  logic [7:0] host_wr_data;
  logic       miso, spi_wr_valid, busy;
  logic [2:0] spi_wr_addr;
  logic [7:0] spi_wr_data, host_rd_data;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model [8];
  logic [10:0] exp_q [$];
  logic [10:0] exp_e;
  bit          host_hold = 1'b0;

  spi_slave_regfile #(.DATA_WIDTH(8), .ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data), .spi_wr_valid(spi_wr_valid),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst) begin
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(spi_wr_valid), 32'd0);
      check("rst_wr_addr", 32'(spi_wr_addr), 32'd0);
      check("rst_wr_data", 32'(spi_wr_data), 32'd0);
    end
    if (spi_wr_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got pulse addr %0d data 0x%0h expected none", spi_wr_addr, spi_wr_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(spi_wr_addr), 32'(exp_e[10:8]));
        check("wr_data", 32'(spi_wr_data), 32'(exp_e[7:0]));
        model[exp_e[10:8]] = exp_e[7:0];
      end
    end
    check("rd_data", 32'(host_rd_data), 32'(model[host_addr]));
  end

  // Driver tasks (all driving happens 1 time unit after a rising clk edge)
  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!host_hold) host_addr = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    host_hold    = 1'b1;
    host_addr    = a;
    host_wr_data = d;
    host_wr_en   = 1'b1;
    @(posedge clk);
    #1;
    model[a]   = d;
    host_wr_en = 1'b0;
    host_hold  = 1'b0;
  endtask

  task automatic check_lit(input logic [2:0] a, input logic [7:0] e);
    host_hold = 1'b1;
    host_addr = a;
    @(negedge clk);
    check($sformatf("lit_reg%0d", a), 32'(host_rd_data), 32'(e));
    @(posedge clk);
    #1;
    host_hold = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] out_b, input int nbits, output logic [7:0] in_b);
    in_b = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = out_b[7-i];
      wait_clks(HALF);
      in_b = {in_b[6:0], miso};
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] data, input int dbits,
                          input int ebits, output logic [7:0] rdata);
    logic [7:0] cm, ex;
    cs = 1'b0;
    wait_clks(HALF);
    spi_bits(cmd, 8, cm);
    check("cmd_miso", 32'(cm), 32'd0);
    check("busy_mid", 32'(busy), 32'd1);
    spi_bits(data, dbits, rdata);
    if (ebits > 0) begin
      spi_bits(8'hFF, ebits, ex);
      check("wait_miso", 32'(ex), 32'd0);
    end
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(8);
    check("wr_pending", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd, t, data, exp_rd;
    logic [2:0] a;
    logic       wr;
    int         n;
    bit         seen;

    // Reset
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    host_wr_en = 1'b0; host_addr = 3'd0; host_wr_data = 8'h00;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    check_lit(3'd0, 8'h00);

    // SPI write 0x85 / 0x3C
    exp_q.push_back({3'd5, 8'h3C});
    spi_xfer(8'h85, 8'h3C, 8, 0, rd);
    check_lit(3'd5, 8'h3C);

    // Host write then SPI read of addr 2
    host_write(3'd2, 8'hA5);
    spi_xfer(8'h02, 8'h00, 8, 0, rd);
    check("read_a5", 32'(rd), 32'hA5);

    // Abort mid data, then a normal transaction
    host_write(3'd1, 8'h77);
    spi_xfer(8'h81, 8'h5A, 4, 0, rd);
    check_lit(3'd1, 8'h77);
    exp_q.push_back({3'd1, 8'hC3});
    spi_xfer(8'h81, 8'hC3, 8, 0, rd);
    check_lit(3'd1, 8'hC3);

    // Extra clocks after the data word
    exp_q.push_back({3'd6, 8'hE7});
    spi_xfer(8'h86, 8'hE7, 8, 3, rd);
    check_lit(3'd6, 8'hE7);

    // Host/SPI collision on addr 3: host writes every cycle until the SPI write lands
    exp_q.push_back({3'd3, 8'h22});
    host_hold = 1'b1; host_addr = 3'd3; host_wr_data = 8'h11; host_wr_en = 1'b1;
    seen = 1'b0;
    fork
      spi_xfer(8'h83, 8'h22, 8, 0, rd);
      begin
        n = 0;
        while (!seen && n < 400) begin
          @(posedge clk);
          #1;
          model[3] = 8'h11;
          n++;
          if (spi_wr_valid === 1'b1) seen = 1'b1;
        end
        host_wr_en = 1'b0;
        host_hold  = 1'b0;
      end
    join
    check("collide_seen", 32'(seen), 32'd1);
    check_lit(3'd3, 8'h22);

    // Reset during the data phase of write 0x87
    exp_q.push_back({3'd7, 8'h99});
    spi_xfer(8'h87, 8'h99, 8, 0, rd);
    cs = 1'b0;
    wait_clks(HALF);
    spi_bits(8'h87, 8, t);
    spi_bits(8'h5A, 4, t);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    exp_q.delete();
    wait_clks(3);
    rst = 1'b0;
    spi_bits(8'hFF, 8, t);
    check("held_cs_busy", 32'(busy), 32'd0);
    check("held_cs_miso", 32'(t), 32'd0);
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(8);
    check_lit(3'd7, 8'h00);
    exp_q.push_back({3'd7, 8'h42});
    spi_xfer(8'h87, 8'h42, 8, 0, rd);
    check_lit(3'd7, 8'h42);

    // Randomized transactions
    for (int k = 0; k < 24; k++) begin
      a    = 3'($urandom_range(0, 7));
      wr   = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      if ($urandom_range(0, 2) == 0) host_write(3'($urandom_range(0, 7)), 8'($urandom));
      exp_rd = model[a];
      if (wr) exp_q.push_back({a, data});
      spi_xfer({wr, 4'($urandom_range(0, 15)), a}, data, 8, $urandom_range(0, 2), rd);
      if (!wr) check("rand_rd", 32'(rd), 32'(exp_rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
